// File: rtl/dp_stage_skid_register.sv
// Elastic pipeline stage register carrying writeback addresses and a payload.
// SKID=1 gives a two-entry skid buffer with registered in_ready; SKID=0 a single register.
module dp_stage_skid_register #(
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned PAYLOAD_W      = 96,
  parameter int unsigned SKID           = 1,
  parameter int unsigned CLEAR_ON_FLUSH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    in_a3,
  input  logic [ADDR_W-1:0]    in_a4,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    out_a3,
  output logic [ADDR_W-1:0]    out_a4,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic                 out_we,
  output logic [1:0]           occupancy
);

  localparam int unsigned EntryW = 2 * ADDR_W + PAYLOAD_W;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e              state_q, state_d;
  logic [EntryW-1:0]   main_q, main_d;
  logic [EntryW-1:0]   skid_q, skid_d;
  logic                main_valid_q, main_valid_d;
  logic                skid_valid_q, skid_valid_d;
  logic [EntryW-1:0]   entry_in;
  logic                push;
  logic                pop;

  assign entry_in = {in_a3, in_a4, in_data};

  // With SKID=1 in_ready depends only on registered state, cutting the ready chain.
  assign in_ready = (SKID != 0) ? (state_q != StTwo) : (!main_valid_q || out_ready);
  assign push     = in_valid && in_ready;
  assign pop      = main_valid_q && out_ready;

  always_comb begin
    state_d      = state_q;
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      state_d      = StEmpty;
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      if (CLEAR_ON_FLUSH != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            state_d      = StOne;
            main_d       = entry_in;
            main_valid_d = 1'b1;
          end
        end
        StOne: begin
          if (push && pop) begin
            main_d = entry_in;
          end else if (push) begin
            state_d      = StTwo;
            skid_d       = entry_in;
            skid_valid_d = 1'b1;
          end else if (pop) begin
            state_d      = StEmpty;
            main_valid_d = 1'b0;
            if (CLEAR_ON_FLUSH != 0) begin
              main_d = '0;
            end
          end
        end
        StTwo: begin
          if (pop) begin
            state_d      = StOne;
            main_d       = skid_q;
            skid_valid_d = 1'b0;
            if (CLEAR_ON_FLUSH != 0) begin
              skid_d = '0;
            end
          end
        end
        default: begin
          state_d      = StEmpty;
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StEmpty;
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid                  = main_valid_q;
  assign {out_a3, out_a4, out_data} = main_q;
  assign out_we                     = main_valid_q && (out_a3 != '0);
  assign occupancy                  = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: doc/dp_stage_skid_register.md
# dp_stage_skid_register

Parametrised, elastic successor to the fixed EX/WB stage register. It carries the writeback addresses (A3, A4) and a configurable-width payload (default RD2, ALUResult, PCNext = 96 bits) between two pipeline stages. A valid/ready handshake replaces the global stall: flushes insert bubbles by clearing the valid bit, and an optional skid entry breaks the combinational ready path. Instances sit at any stage boundary, EX→WB first.

## Interface
Parameters:
- ADDR_W, 5: width of each register-address field (A3, A4).
- PAYLOAD_W, 96: payload width; the EX/WB packing is {RD2, ALUResult, PCNext}, MSB first.
- SKID, 1: 1 selects a two-entry skid buffer with registered in_ready; 0 selects a single register with combinational in_ready.
- CLEAR_ON_FLUSH, 1: 1 zeroes the data fields of flushed entries; 0 clears only the valid bits.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  kills every held entry and any entry accepted in the same cycle.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  block accepts an entry this cycle.
- in_a3  in  ADDR_W  destination register address.
- in_a4  in  ADDR_W  second destination address.
- in_data  in  PAYLOAD_W  payload.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream consumes the head this cycle.
- out_a3, out_a4  out  ADDR_W  head addresses.
- out_data  out  PAYLOAD_W  head payload.
- out_we  out  1  high when out_valid=1 and out_a3≠0; the writeback enable.
- occupancy  out  2  number of held entries (0–2).

## Operation
- Push: in_valid & in_ready. Pop: out_valid & out_ready. Entries leave in FIFO order.
- SKID=1 storage: main register (head) plus skid register. States:
  - EMPTY: push → ONE.
  - ONE: push & !pop → TWO; pop & !push → EMPTY; push & pop → ONE, new entry becomes head.
  - TWO: pop → ONE, skid moves to main. Push is impossible in TWO because in_ready=0.
- SKID=1: in_ready = (state≠TWO), decoded only from registers. There is no combinational path from out_ready to in_ready.
- SKID=0: one register. in_ready = !out_valid | out_ready. occupancy is at most 1.
- Flush takes priority over push and pop. On the next edge, state=EMPTY and all valid bits are 0. With CLEAR_ON_FLUSH=1, the addresses and payload of both entries also become 0. A push that coincides with a flush is discarded.
- Outputs are driven directly from the main register. Nothing is computed on the output path except out_we and occupancy.
- Data fields of an invalid entry are don't-care when CLEAR_ON_FLUSH=0 and zero when CLEAR_ON_FLUSH=1.

## Timing
- Reset (reset=0, asynchronous): state EMPTY; out_valid=0, out_we=0, out_a3=0, out_a4=0, out_data=0, occupancy=0. in_ready=1 in both modes while reset is held and after release.
- Asserting reset mid-transfer drops all held entries immediately, without waiting for a clock edge.
- Latency: an entry pushed at edge N is visible on the outputs after edge N. It is consumed at the first edge where out_ready=1.
- Throughput: one entry per cycle sustained when out_ready stays at 1.
- SKID=1, out_ready falls while streaming: the entry pushed in that cycle lands in skid, and in_ready falls after the same edge. No entry is lost or duplicated.
- TWO with out_ready=1: after the edge, the skid entry is the head, occupancy=1 and in_ready=1.
- Flush and pop in the same cycle: the pop completes downstream, and the block is EMPTY after the edge.
- A flush while reset is held has no effect.

## Test plan
- Reset: hold reset=0 with in_valid=1 and in_a3=7 → out_valid=0, out_data=0, occupancy=0. After release, the first push makes out_a3=7 one edge later.
- Streaming (SKID=1): push payloads 1..8 back-to-back with out_ready=1 → payloads 1..8 appear on consecutive cycles, one cycle after each push; occupancy holds at 1.
- Backpressure: push A then B while out_ready=0 → occupancy=2 and in_ready=0. Raise out_ready → out_data=A, then B on the next cycle. in_ready returns to 1 after the first pop.
- Flush: in TWO, assert flush together with in_valid=1 → state EMPTY, out_valid=0 and out_data=0 (CLEAR_ON_FLUSH=1); the entry pushed with the flush never appears.
- Writeback enable: push in_a3=0, then in_a3=5 → out_we=0, then out_we=1.
- SKID=0: with out_valid=1 and out_ready=1, in_ready=1 in the same cycle. With out_ready=0, in_ready=0 and occupancy never exceeds 1.
